// File: rtl/ex_cond_flags_stage.sv
// rtl/ex_cond_flags_stage.sv - NZCV flag register, condition evaluation and 1-deep output slot
// Optional COND_STATS_EN adds saturating exec_cnt / squash_cnt counters.
module ex_cond_flags_stage #(
  parameter int N          = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          alu_result,
  input  logic [3:0]            alu_flags,
  input  logic [3:0]            cond,
  input  logic [1:0]            flag_write,
  input  logic                  reg_write_in,
  input  logic                  mem_write_in,
  input  logic                  pc_src_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic [N-1:0]          wdata_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0]          out_result,
  output logic [N-1:0]          out_wdata,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic                  out_mem_write,
  output logic                  out_pc_src,
  output logic [3:0]            flags_q
`ifdef COND_STATS_EN
  ,
  output logic [15:0]           exec_cnt,
  output logic [15:0]           squash_cnt
`endif
);

  logic accept;
  logic cond_ex;
  logic f_n, f_z, f_c, f_v;

  assign {f_n, f_z, f_c, f_v} = flags_q;
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready & ~flush;

  // Evaluated on the registered flags, so an instruction never sees its own update.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'h0:    cond_ex = f_z;
      4'h1:    cond_ex = ~f_z;
      4'h2:    cond_ex = f_c;
      4'h3:    cond_ex = ~f_c;
      4'h4:    cond_ex = f_n;
      4'h5:    cond_ex = ~f_n;
      4'h6:    cond_ex = f_v;
      4'h7:    cond_ex = ~f_v;
      4'h8:    cond_ex = f_c & ~f_z;
      4'h9:    cond_ex = ~f_c | f_z;
      4'hA:    cond_ex = (f_n == f_v);
      4'hB:    cond_ex = (f_n != f_v);
      4'hC:    cond_ex = ~f_z & (f_n == f_v);
      4'hD:    cond_ex = f_z | (f_n != f_v);
      4'hE:    cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_wdata     <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_mem_write <= 1'b0;
      out_pc_src    <= 1'b0;
      flags_q       <= 4'h0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_result    <= alu_result;
      out_wdata     <= wdata_in;
      out_rd        <= rd_in;
      out_reg_write <= reg_write_in & cond_ex;
      out_mem_write <= mem_write_in & cond_ex;
      out_pc_src    <= pc_src_in & cond_ex;
      if (cond_ex && flag_write[1]) flags_q[3:2] <= alu_flags[3:2];
      if (cond_ex && flag_write[0]) flags_q[1:0] <= alu_flags[1:0];
    end else if (out_ready) begin
      // Pop only: data registers keep their last values.
      out_valid <= 1'b0;
    end
  end

`ifdef COND_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      exec_cnt   <= 16'h0;
      squash_cnt <= 16'h0;
    end else if (accept) begin
      if (cond_ex && exec_cnt != 16'hFFFF)      exec_cnt   <= exec_cnt + 16'h1;
      if (!cond_ex && squash_cnt != 16'hFFFF)   squash_cnt <= squash_cnt + 16'h1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_cond_flags_stage.sv
// tb/tb_ex_cond_flags_stage.sv - directed + random bench for ex_cond_flags_stage
// Define COND_STATS_EN for both files to exercise the statistics counters.
module tb_ex_cond_flags_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_result = '0;
  logic [3:0]  alu_flags = '0;
  logic [3:0]  cond = '0;
  logic [1:0]  flag_write = '0;
  logic        reg_write_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic        pc_src_in = 1'b0;
  logic [3:0]  rd_in = '0;
  logic [31:0] wdata_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [31:0] out_wdata;
  logic [3:0]  out_rd;
  logic        out_reg_write;
  logic        out_mem_write;
  logic        out_pc_src;
  logic [3:0]  flags_q;
`ifdef COND_STATS_EN
  logic [15:0] exec_cnt;
  logic [15:0] squash_cnt;
`endif

  ex_cond_flags_stage #(.N(32), .REG_ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_flags(alu_flags), .cond(cond), .flag_write(flag_write),
    .reg_write_in(reg_write_in), .mem_write_in(mem_write_in), .pc_src_in(pc_src_in),
    .rd_in(rd_in), .wdata_in(wdata_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_wdata(out_wdata), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_write(out_mem_write), .out_pc_src(out_pc_src),
    .flags_q(flags_q)
`ifdef COND_STATS_EN
    , .exec_cnt(exec_cnt), .squash_cnt(squash_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  bit          m_valid;
  bit [31:0]   m_result, m_wdata;
  bit [3:0]    m_rd;
  bit          m_rw, m_mw, m_pc;
  bit [3:0]    m_flags;
  int          m_exec, m_squash;

  function automatic bit cond_pass(input bit [3:0] c, input bit [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      0: return z;            1: return !z;
      2: return cy;           3: return !cy;
      4: return n;            5: return !n;
      6: return v;            7: return !v;
      8: return cy && !z;     9: return !cy || z;
      10: return n == v;      11: return n != v;
      12: return !z && n == v; 13: return z || n != v;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit iv, input bit [3:0] c, input bit [1:0] fw, input bit [3:0] af,
                        input bit rw, input bit mw, input bit pc);
    in_valid = iv; cond = c; flag_write = fw; alu_flags = af;
    reg_write_in = rw; mem_write_in = mw; pc_src_in = pc;
    alu_result = $urandom; wdata_in = $urandom; rd_in = 4'($urandom);
  endtask

  // One clock: check in_ready, advance the model, check every output after the edge.
  task automatic tick();
    bit exp_ready, acc, ce;
    #1;
    exp_ready = !m_valid || out_ready;
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
    acc = in_valid && exp_ready && !flush;
    ce  = cond_pass(cond, m_flags);
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_result = 0; m_wdata = 0; m_rd = 0;
      m_rw = 0; m_mw = 0; m_pc = 0; m_flags = 0; m_exec = 0; m_squash = 0;
    end else if (flush) begin
      m_valid = 0;
    end else if (acc) begin
      m_valid = 1; m_result = alu_result; m_wdata = wdata_in; m_rd = rd_in;
      m_rw = reg_write_in && ce; m_mw = mem_write_in && ce; m_pc = pc_src_in && ce;
      if (ce && flag_write[1]) m_flags[3:2] = alu_flags[3:2];
      if (ce && flag_write[0]) m_flags[1:0] = alu_flags[1:0];
      if (ce) m_exec = (m_exec < 65535) ? m_exec + 1 : 65535;
      else    m_squash = (m_squash < 65535) ? m_squash + 1 : 65535;
    end else if (out_ready) begin
      m_valid = 0;
    end
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    chk("out_result", out_result, m_result);
    chk("out_wdata", out_wdata, m_wdata);
    chk("out_rd", {28'b0, out_rd}, {28'b0, m_rd});
    chk("out_reg_write", {31'b0, out_reg_write}, {31'b0, m_rw});
    chk("out_mem_write", {31'b0, out_mem_write}, {31'b0, m_mw});
    chk("out_pc_src", {31'b0, out_pc_src}, {31'b0, m_pc});
    chk("flags_q", {28'b0, flags_q}, {28'b0, m_flags});
`ifdef COND_STATS_EN
    chk("exec_cnt", {16'b0, exec_cnt}, m_exec);
    chk("squash_cnt", {16'b0, squash_cnt}, m_squash);
`endif
  endtask

  initial begin
    // 1: reset
    rst = 1; tick(); tick();
    chk("t1_in_ready", {31'b0, in_ready}, 32'd1);
    chk("t1_flags", {28'b0, flags_q}, 32'd0);
    rst = 0;

    // 2: AL writes Z, then EQ executes and NE squashes
    set_in(1, 4'hE, 2'b11, 4'b0100, 0, 0, 0); alu_result = 0; tick();
    set_in(1, 4'h0, 2'b00, 4'b0000, 1, 0, 0); tick();
    chk("t2_flags", {28'b0, flags_q}, 32'b0100);
    chk("t2_eq_rw", {31'b0, out_reg_write}, 32'd1);
    set_in(1, 4'h1, 2'b00, 4'b0000, 1, 0, 0); tick();
    chk("t2_ne_rw", {31'b0, out_reg_write}, 32'd0);
    chk("t2_ne_valid", {31'b0, out_valid}, 32'd1);

    // 3: N,V set -> GE executes, LT squashed with no flag update
    set_in(1, 4'hE, 2'b11, 4'b1001, 0, 0, 0); tick();
    set_in(1, 4'hA, 2'b00, 4'b0000, 0, 1, 0); tick();
    chk("t3_ge_mw", {31'b0, out_mem_write}, 32'd1);
    set_in(1, 4'hB, 2'b11, 4'b0010, 1, 1, 1); tick();
    chk("t3_lt_flags", {28'b0, flags_q}, 32'b1001);
    chk("t3_lt_mw", {31'b0, out_mem_write}, 32'd0);

    // 4: stall three cycles, then pop+push on the same edge
    out_ready = 0;
    set_in(1, 4'hE, 2'b00, 4'b0000, 1, 1, 1);
    repeat (3) begin
      tick();
      chk("t4_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1; tick();
    chk("t4_valid", {31'b0, out_valid}, 32'd1);
    chk("t4_pc", {31'b0, out_pc_src}, 32'd1);

    // 5: flush drops the input and keeps flags
    flush = 1; set_in(1, 4'hE, 2'b11, 4'b1111, 1, 1, 1); tick(); flush = 0;
    chk("t5_valid", {31'b0, out_valid}, 32'd0);
    chk("t5_flags", {28'b0, flags_q}, 32'b1001);

    // pop without push after reloading the slot
    set_in(1, 4'h9, 2'b01, 4'b0011, 1, 0, 0); tick();
    set_in(0, 4'h0, 2'b00, 4'b0000, 0, 0, 0); tick();
    chk("pop_valid", {31'b0, out_valid}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      set_in($urandom_range(0, 4) != 0, 4'($urandom), 2'($urandom), 4'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    rst = 0; flush = 0; out_ready = 1;

`ifdef COND_STATS_EN
    // 6: 3 executed + 2 squashed, then saturation
    rst = 1; tick(); rst = 0;
    repeat (3) begin set_in(1, 4'hE, 2'b00, 4'b0000, 0, 0, 0); tick(); end
    repeat (2) begin set_in(1, 4'hF, 2'b00, 4'b0000, 0, 0, 0); tick(); end
    chk("t6_exec3", {16'b0, exec_cnt}, 32'd3);
    chk("t6_squash2", {16'b0, squash_cnt}, 32'd2);
    rst = 1; tick(); rst = 0;
    set_in(1, 4'hE, 2'b00, 4'b0000, 0, 0, 0);
    repeat (70000) @(posedge clk);
    #1;
    chk("t6_exec_sat", {16'b0, exec_cnt}, 32'hFFFF);
    chk("t6_squash0", {16'b0, squash_cnt}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
